clk_en_sched: RTL

//  Clock-enable scheduler sharing the single free-running clk between NUM_CH consumers.

---
 rtl/clk_en_sched_pkg.sv | 10 +
 rtl/clk_en_sched_ch.sv | 41 ++++
 rtl/clk_en_sched.sv | 67 ++++++
 3 files changed

// File: rtl/clk_en_sched_pkg.sv
// clk_en_sched_pkg: shared state encoding and index-width helper for the clock-enable scheduler.
package clk_en_sched_pkg;

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_en_sched_ch.sv
// clk_en_sched_ch: one enable channel with shadow/active divider and period counter.
// Mid-period strobe is built only when CLK_EN_SCHED_HALF_EN is defined.
module clk_en_sched_ch #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             we,
   input  logic [DIV_W-1:0] div,
   output logic             en,
   output logic             half
);

   logic [DIV_W-1:0] cnt, div_sh, div_act;

   assign en = run && (cnt == div_act);

`ifdef CLK_EN_SCHED_HALF_EN
   logic [DIV_W:0] per;
   assign per  = {1'b0, div_act} + (DIV_W+1)'(1);
   assign half = run && (div_act != '0) && ({1'b0, cnt} == (per >> 1));
`else
   assign half = 1'b0;
`endif

   // Outside RUN writes apply at once; inside RUN the new period starts after the next strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         div_sh  <= '0;
         div_act <= '0;
      end else begin
         if (we) div_sh <= div;
         cnt <= (run && !en) ? cnt + DIV_W'(1) : '0;
         if (!run && we) div_act <= div;
         else if (en) div_act <= div_sh;
      end
   end

endmodule

// File: rtl/clk_en_sched.sv
// clk_en_sched: run controller and NUM_CH clock-enable channels sharing one clk.
// Define CLK_EN_SCHED_HALF_EN to enable the per-channel mid-period half_o strobe.
module clk_en_sched
   import clk_en_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8,
   parameter int CYC_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      stop_i,
   input  logic [CYC_W-1:0]          budget_i,
   input  logic                      cfg_we_i,
   input  logic [idx_w(NUM_CH)-1:0]  cfg_idx_i,
   input  logic [DIV_W-1:0]          cfg_div_i,
   output logic [NUM_CH-1:0]         en_o,
   output logic [NUM_CH-1:0]         half_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [CYC_W-1:0]          cyc_o
);

   localparam int IW = idx_w(NUM_CH);

   state_e           state;
   logic [CYC_W-1:0] cyc, budget;
   logic             run, last;

   assign run  = (state == RUN);
   assign last = stop_i || ((budget != '0) && (cyc == budget - CYC_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cyc    <= '0;
         budget <= '0;
      end else if (state == IDLE && start_i) begin
         state  <= RUN;
         cyc    <= '0;
         budget <= budget_i;
      end else if (run) begin
         cyc <= cyc + CYC_W'(1);
         if (last) state <= STOP;
      end else if (state == STOP) begin
         state <= IDLE;
      end
   end

   assign busy_o = (state != IDLE);
   assign done_o = (state == STOP);
   assign cyc_o  = cyc;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      clk_en_sched_ch #(.DIV_W(DIV_W)) u_ch (
         .clk  (clk),
         .rst  (rst),
         .run  (run),
         .we   (cfg_we_i && (cfg_idx_i == IW'(c))),
         .div  (cfg_div_i),
         .en   (en_o[c]),
         .half (half_o[c])
      );
   end

endmodule
